// File: rtl/negator_pipe.sv
// Elastic valid/ready chain of DEPTH registered bitwise-negator stages with a per-item bypass tag.
// Optional output-transfer counter enabled by defining NEGATOR_PIPE_XFER_COUNT_EN.
module negator_pipe #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 2,
   localparam int OCC_W = $clog2(DEPTH + 1)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_bypass,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_bypass,
   output logic [OCC_W-1:0] occupancy
`ifdef NEGATOR_PIPE_XFER_COUNT_EN
   ,
   output logic [15:0]      xfer_count
`endif
);

   logic [DEPTH-1:0] stage_valid;
   logic [DEPTH-1:0] stage_tag;
   logic [WIDTH-1:0] stage_data [DEPTH];

   logic [DEPTH-1:0] up_valid;
   logic [DEPTH-1:0] up_tag;
   logic [WIDTH-1:0] up_data [DEPTH];

   logic [DEPTH-1:0] rdy;

   logic             in_xfer;
   logic             out_xfer;
   logic [OCC_W-1:0] occ_q, occ_d;

   for (genvar k = 0; k < DEPTH; k++) begin : g_stage
      logic             valid_q, valid_d;
      logic             tag_q, tag_d;
      logic [WIDTH-1:0] data_q, data_d;

      if (k == 0) begin : g_head
         assign up_valid[k] = in_valid;
         assign up_tag[k]   = in_bypass;
         assign up_data[k]  = in_data;
      end else begin : g_body
         assign up_valid[k] = stage_valid[k-1];
         assign up_tag[k]   = stage_tag[k-1];
         assign up_data[k]  = stage_data[k-1];
      end

      // A stage can move when any stage from here to the tail has a hole, or the tail drains.
      assign rdy[k] = out_ready || !(&stage_valid[DEPTH-1:k]);

      always_comb begin
         valid_d = valid_q;
         tag_d   = tag_q;
         data_d  = data_q;
         if (rdy[k]) begin
            valid_d = up_valid[k];
            if (up_valid[k]) begin
               tag_d  = up_tag[k];
               data_d = up_tag[k] ? up_data[k] : ~up_data[k];
            end
         end
      end

      always_ff @(posedge clock) begin
         if (reset) begin
            valid_q <= 1'b0;
            tag_q   <= 1'b0;
            data_q  <= '0;
         end else begin
            valid_q <= valid_d;
            tag_q   <= tag_d;
            data_q  <= data_d;
         end
      end

      assign stage_valid[k] = valid_q;
      assign stage_tag[k]   = tag_q;
      assign stage_data[k]  = data_q;
   end

   assign in_ready   = rdy[0];
   assign out_valid  = stage_valid[DEPTH-1];
   assign out_bypass = stage_tag[DEPTH-1];
   assign out_data   = stage_data[DEPTH-1];

   assign in_xfer  = in_valid && rdy[0];
   assign out_xfer = stage_valid[DEPTH-1] && out_ready;

   // Item count tracks transfers, which always equals the number of valid stages.
   always_comb begin
      occ_d = occ_q;
      if (in_xfer && !out_xfer) begin
         occ_d = occ_q + 1'b1;
      end else if (!in_xfer && out_xfer) begin
         occ_d = occ_q - 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         occ_q <= '0;
      end else begin
         occ_q <= occ_d;
      end
   end

   assign occupancy = occ_q;

`ifdef NEGATOR_PIPE_XFER_COUNT_EN
   logic [15:0] xfer_q, xfer_d;

   always_comb begin
      xfer_d = xfer_q;
      if (out_xfer) begin
         xfer_d = xfer_q + 16'd1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         xfer_q <= '0;
      end else begin
         xfer_q <= xfer_d;
      end
   end

   assign xfer_count = xfer_q;
`endif

endmodule
